// File: rtl/nv_clk_gate_pkg.sv
// Shared types and helpers for the multi-channel clock-gating controller.
// Stats width is used only when NV_CLK_GATE_STATS_EN is defined.
package nv_clk_gate_pkg;

    typedef enum logic [1:0] {
        CG_RUN  = 2'd0,
        CG_OFF  = 2'd1,
        CG_WAKE = 2'd2
    } cg_state_e;

    localparam int CG_STAT_W = 32;

    // Width of the per-channel counter: must hold max(idle, wake).
    function automatic int cg_cnt_w(input int idle, input int wake);
        int m;
        m = (idle > wake) ? idle : wake;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/nv_cg_cell.sv
// Glitch-free clock gate: enable latched while clk is low, then ANDed with clk.
// The only latch/negedge logic in the design; swap for a library ICG cell here.
module nv_cg_cell (
    input  logic clk,
    input  logic te,
    input  logic e,
    output logic q
);

    logic en_lat;

    always_latch begin
        if (!clk) begin
            en_lat <= te | e;
        end
    end

    assign q = clk & en_lat;

endmodule

// File: rtl/nv_clk_gate_ctrl.sv
// Multi-channel clock-gating controller with idle hysteresis and wake handshake.
// Optional per-channel OFF-cycle statistics when NV_CLK_GATE_STATS_EN is defined.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   CG_RUN  | clock running, rdy=1; counts consecutive idle cycles
//   CG_OFF  | clock gated, gated=1; waits for busy or cg_disable
//   CG_WAKE | clock running, rdy=0; counts WAKE_CYCLES before RUN
module nv_clk_gate_ctrl
    import nv_clk_gate_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rst,
    input  logic              test_en,
    input  logic [NUM_CH-1:0] busy,
    input  logic [NUM_CH-1:0] cg_disable,
    output logic [NUM_CH-1:0] rdy,
    output logic [NUM_CH-1:0] gclk,
    output logic [NUM_CH-1:0] gated
`ifdef NV_CLK_GATE_STATS_EN
    ,
    input  logic                        stats_clr,
    output logic [NUM_CH*CG_STAT_W-1:0] gated_cnt
`endif
);

    localparam int CNT_W = cg_cnt_w(IDLE_CYCLES, WAKE_CYCLES);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    // Clamped so the compare stays well-formed when WAKE_CYCLES is 0; that
    // case never enters CG_WAKE.
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);

    logic [NUM_CH-1:0] fsm_en;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch

        cg_state_e        state_q;
        cg_state_e        state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             req;

        assign req = busy[i] | cg_disable[i];

        always_ff @(posedge nvdla_core_clk) begin
            if (nvdla_core_rst) begin
                state_q <= CG_RUN;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                CG_RUN: begin
                    if (req) begin
                        cnt_d = '0;
                    end else if (cnt_q == IDLE_LAST) begin
                        state_d = CG_OFF;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                CG_OFF: begin
                    if (req) begin
                        cnt_d = '0;
                        if (WAKE_CYCLES == 0) begin
                            state_d = CG_RUN;
                        end else begin
                            state_d = CG_WAKE;
                        end
                    end
                end
                CG_WAKE: begin
                    // A dropped request does not abort the wake.
                    if (cnt_q == WAKE_LAST) begin
                        state_d = CG_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = CG_RUN;
                    cnt_d   = '0;
                end
            endcase
        end

        assign rdy[i]    = (state_q == CG_RUN);
        assign gated[i]  = (state_q == CG_OFF);
        assign fsm_en[i] = (state_q != CG_OFF);

        nv_cg_cell u_cell (
            .clk (nvdla_core_clk),
            .te  (test_en),
            .e   (fsm_en[i]),
            .q   (gclk[i])
        );

`ifdef NV_CLK_GATE_STATS_EN
        logic [CG_STAT_W-1:0] stat_q;

        always_ff @(posedge nvdla_core_clk) begin
            if (nvdla_core_rst || stats_clr) begin
                stat_q <= '0;
            end else if ((state_q == CG_OFF) && (stat_q != {CG_STAT_W{1'b1}})) begin
                stat_q <= stat_q + 1'b1;
            end
        end

        assign gated_cnt[i*CG_STAT_W +: CG_STAT_W] = stat_q;
`endif

    end

endmodule

// File: tb/tb_nv_clk_gate_ctrl.sv
// Scoreboard bench for nv_clk_gate_ctrl (NUM_CH=4, IDLE_CYCLES=16, WAKE_CYCLES=2).
// Stimulus queues expected values tagged with a due cycle; the monitor checks them.
module tb_nv_clk_gate_ctrl;

    localparam int K_RDY   = 0;
    localparam int K_GATED = 1;
    localparam int K_MARK  = 2;
    localparam int K_DELTA = 3;
    localparam int K_STAT  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       test_en = 1'b0;
    logic [3:0] busy = 4'h0;
    logic [3:0] cg_disable = 4'h0;
    logic [3:0] rdy;
    logic [3:0] gclk;
    logic [3:0] gated;
`ifdef NV_CLK_GATE_STATS_EN
    logic         stats_clr = 1'b0;
    logic [127:0] gated_cnt;
`endif

    nv_clk_gate_ctrl #(
        .NUM_CH      (4),
        .IDLE_CYCLES (16),
        .WAKE_CYCLES (2)
    ) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .test_en        (test_en),
        .busy           (busy),
        .cg_disable     (cg_disable),
        .rdy            (rdy),
        .gclk           (gclk),
        .gated          (gated)
`ifdef NV_CLK_GATE_STATS_EN
        ,
        .stats_clr      (stats_clr),
        .gated_cnt      (gated_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int gcnt [4] = '{default: 0};
    int base [4] = '{default: 0};
    for (genvar g = 0; g < 4; g++) begin : g_cnt
        always @(posedge gclk[g]) gcnt[g] = gcnt[g] + 1;
    end

    typedef struct {
        int          due;
        int          kind;
        int          ch;
        logic [31:0] v;
        int          tag;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input int off, input int kind, input int ch, input logic [31:0] v, input int tag);
        sb.push_back('{cyc + off, kind, ch, v, tag});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] got;
        string       nm;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e   = sb.pop_front();
            got = '0;
            nm  = "";
            case (e.kind)
                K_RDY:   begin got = {28'b0, rdy};   nm = "rdy";   end
                K_GATED: begin got = {28'b0, gated}; nm = "gated"; end
                K_DELTA: begin got = gcnt[e.ch] - base[e.ch]; nm = "gclk_pulses"; end
`ifdef NV_CLK_GATE_STATS_EN
                K_STAT:  begin got = gated_cnt[31:0]; nm = "gated_cnt0"; end
`endif
                default: nm = "mark";
            endcase
            if (e.kind == K_MARK) begin
                for (int c = 0; c < 4; c++) base[c] = gcnt[c];
            end else begin
                n_chk++;
                if (e.due != cyc || got !== e.v) begin
                    n_fail++;
                    $display("FAIL %s t%0d ch%0d cyc%0d (due %0d): got %0h want %0h",
                             nm, e.tag, e.ch, cyc, e.due, got, e.v);
                end
            end
        end
    end

    initial begin
        // 1: clocks run during reset, then 16 idle pulses and all channels gate
        rst = 1'b1;
        tick(1);
        chk(0, K_MARK, 0, 0, 1);
        chk(2, K_RDY, 0, 4'hF, 1);
        chk(2, K_GATED, 0, 4'h0, 1);
        for (int c = 0; c < 4; c++) chk(2, K_DELTA, c, 2, 1);
        tick(2);
        rst = 1'b0;
        chk(0, K_MARK, 0, 0, 1);
        chk(15, K_GATED, 0, 4'h0, 1);
        chk(16, K_GATED, 0, 4'hF, 1);
        chk(16, K_RDY, 0, 4'h0, 1);
        for (int c = 0; c < 4; c++) chk(18, K_DELTA, c, 16, 1);
        tick(18);

        // 2: one-cycle busy pulse wakes ch1; rdy after WAKE_CYCLES, re-gates later
        busy[1] = 1'b1;
        chk(0, K_MARK, 0, 0, 2);
        chk(1, K_GATED, 0, 4'hD, 2);
        chk(2, K_RDY, 0, 4'h0, 2);
        chk(3, K_RDY, 0, 4'h2, 2);
        chk(18, K_RDY, 0, 4'h2, 2);
        chk(19, K_GATED, 0, 4'hF, 2);
        chk(19, K_RDY, 0, 4'h0, 2);
        chk(21, K_DELTA, 1, 18, 2);
        chk(21, K_DELTA, 0, 0, 2);
        tick(1);
        busy[1] = 1'b0;
        tick(20);

        // 3: ch2 busy every 10 cycles never reaches the idle threshold
        for (int k = 0; k < 10; k++) begin
            busy[2] = 1'b1;
            chk(5, K_GATED, 0, 4'hB, 3);
            chk(5, K_RDY, 0, 4'h4, 3);
            tick(1);
            busy[2] = 1'b0;
            tick(9);
        end
        tick(8);

        // 4: test_en runs all clocks without changing state
        chk(0, K_GATED, 0, 4'hF, 4);
        test_en = 1'b1;
        chk(0, K_MARK, 0, 0, 4);
        chk(5, K_GATED, 0, 4'hF, 4);
        chk(5, K_RDY, 0, 4'h0, 4);
        tick(10);
        test_en = 1'b0;
        for (int c = 0; c < 4; c++) chk(4, K_DELTA, c, 10, 4);
        chk(4, K_GATED, 0, 4'hF, 4);
        tick(4);

        // 5: reset mid-WAKE returns to RUN; cg_disable[3] keeps ch3 running
        busy[0] = 1'b1;
        tick(1);
        busy[0] = 1'b0;
        rst = 1'b1;
        cg_disable[3] = 1'b1;
        chk(0, K_RDY, 0, 4'h0, 5);
        chk(0, K_GATED, 0, 4'hE, 5);
        chk(1, K_RDY, 0, 4'hF, 5);
        chk(1, K_GATED, 0, 4'h0, 5);
        chk(16, K_GATED, 0, 4'h0, 5);
        chk(17, K_GATED, 0, 4'h7, 5);
        chk(17, K_RDY, 0, 4'h8, 5);
        chk(17, K_MARK, 0, 0, 5);
        tick(1);
        rst = 1'b0;
        tick(1016);
        chk(0, K_DELTA, 3, 1000, 5);
        chk(0, K_DELTA, 0, 0, 5);
        chk(0, K_GATED, 0, 4'h7, 5);

`ifdef NV_CLK_GATE_STATS_EN
        // 6: OFF-cycle counter, clear, and clear-beats-increment
        chk(0, K_STAT, 0, 1000, 6);
        stats_clr = 1'b1;
        tick(1);
        stats_clr = 1'b0;
        chk(50, K_STAT, 0, 50, 6);
        tick(50);
        stats_clr = 1'b1;
        chk(1, K_STAT, 0, 0, 6);
        tick(1);
        stats_clr = 1'b0;
`endif

        for (int t = 0; t < 20 && sb.size() > 0; t++) tick(1);
        if (sb.size() > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
